seq_divider: RTL and testbench

- Multi-cycle signed integer divider that sits in the ALU slot behind the Y register and bus.
- Dividend (Q) comes from Y; divisor (M) comes from the bus.
- Quotient is delivered to the Zlow path and remainder to the Zhigh path, replacing the single-cycle DIV.
- The control sequencer holds the DIV step until done pulses, then performs Zlowout/LOin and Zhighout/HIin as before.

---
 rtl/seq_divider_pkg.sv | 15 +
 rtl/seq_divider_step.sv | 27 ++
 rtl/seq_divider.sv | 114 +++++++++++
 tb/tb_seq_divider.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the multi-cycle signed divider and the sequencer that drives it.
// The sequencer holds its DIV step on OPC_DIV until the divider pulses done.
package seq_divider_pkg;

   localparam int unsigned DIV_WIDTH = 32;

   localparam logic [4:0] OPC_DIV = 5'b01111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ITER = 2'd1,
      ST_FIX  = 2'd2
   } div_state_e;

endpackage : seq_divider_pkg

// File: rtl/seq_divider_step.sv
// One non-restoring division iteration: shift {A,Q} left, then add or subtract M
// depending on the sign of A before the step.
module div_nr_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH:0]   a_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic [WIDTH-1:0] m_i,
   output logic [WIDTH:0]   a_o,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH:0]   a_sh;
   logic [WIDTH-1:0] q_sh;

   always_comb begin
      a_sh = {a_i[WIDTH-1:0], q_i[WIDTH-1]};
      q_sh = {q_i[WIDTH-2:0], 1'b0};
      if (a_i[WIDTH]) begin
         a_o = a_sh + {1'b0, m_i};
      end else begin
         a_o = a_sh - {1'b0, m_i};
      end
      q_o = {q_sh[WIDTH-1:1], ~a_o[WIDTH]};
   end

endmodule : div_nr_step

// File: rtl/seq_divider.sv
// Multi-cycle signed divider: quotient to Zlow, remainder to Zhigh, fixed WIDTH+1 edge
// latency from the accept edge to done, truncating toward zero.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   div_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH:0]   a_q, a_d;
   logic [WIDTH-1:0] q_q, q_d, m_q;
   logic             sign_q_q, sign_m_q, zero_q;
   logic             busy_q, done_q, dbz_q;
   logic [WIDTH-1:0] quot_q, rem_q;
   logic [WIDTH-1:0] rem_mag, quot_fix, rem_fix;

   div_nr_step #(.WIDTH(WIDTH)) u_step (
      .a_i (a_q),
      .q_i (q_q),
      .m_i (m_q),
      .a_o (a_d),
      .q_o (q_d)
   );

   // With M == 0 every step subtracts zero, so A ends up holding |dividend| and the
   // ordinary sign fix-up already reproduces the dividend as the remainder.
   always_comb begin
      rem_mag = a_q[WIDTH] ? (a_q[WIDTH-1:0] + m_q) : a_q[WIDTH-1:0];
      rem_fix = sign_q_q ? -rem_mag : rem_mag;
      if (zero_q) begin
         quot_fix = '1;
      end else if (sign_q_q ^ sign_m_q) begin
         quot_fix = -q_q;
      end else begin
         quot_fix = q_q;
      end
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         q_q      <= '0;
         m_q      <= '0;
         sign_q_q <= 1'b0;
         sign_m_q <= 1'b0;
         zero_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
         quot_q   <= '0;
         rem_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  state_q  <= ST_ITER;
                  sign_q_q <= dividend[WIDTH-1];
                  sign_m_q <= divisor[WIDTH-1];
                  q_q      <= dividend[WIDTH-1] ? -dividend : dividend;
                  m_q      <= divisor[WIDTH-1] ? -divisor : divisor;
                  a_q      <= '0;
                  cnt_q    <= CNT_W'(WIDTH);
                  zero_q   <= (divisor == '0);
                  busy_q   <= 1'b1;
               end
            end
            ST_ITER: begin
               a_q   <= a_d;
               q_q   <= q_d;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= ST_FIX;
               end
            end
            ST_FIX: begin
               state_q <= ST_IDLE;
               quot_q  <= quot_fix;
               rem_q   <= rem_fix;
               dbz_q   <= zero_q;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expected results are queued when an operation is
// launched and compared when done pulses.
module tb_seq_divider;

   logic        clock = 1'b0;
   logic        clear = 1'b0;
   logic        start = 1'b0;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic        busy, done, div_by_zero;
   logic [31:0] quotient, remainder;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        z;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   seq_divider #(.WIDTH(32), .CNT_W(6)) dut (
      .clock       (clock),
      .clear       (clear),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      if (b == 32'd0) begin
         e.q = 32'hFFFF_FFFF;
         e.r = a;
         e.z = 1'b1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         e.q = 32'h8000_0000;
         e.r = 32'd0;
         e.z = 1'b0;
      end else begin
         e.q = 32'($signed(a) / $signed(b));
         e.r = 32'($signed(a) % $signed(b));
         e.z = 1'b0;
      end
      return e;
   endfunction

   // restart_at: edge after accept where a stray start (other operands) is pulsed;
   // clear_at: edge after accept where clear is driven low mid-operation.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input int restart_at, input int clear_at);
      int   cyc;
      int   busy_cnt;
      bit   got;
      exp_t e;
      @(negedge clock);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      sb.push_back(model(a, b));
      @(posedge clock);
      #1;
      start    = 1'b0;
      dividend = 32'hDEAD_BEEF;
      divisor  = 32'h0000_0003;
      busy_cnt = busy ? 1 : 0;
      cyc      = 0;
      got      = 1'b0;
      while (cyc < 100 && !got) begin
         @(posedge clock);
         #1;
         cyc++;
         start = 1'b0;
         if (cyc == restart_at) begin
            dividend = 32'd50;
            divisor  = 32'd5;
            start    = 1'b1;
         end
         if (cyc == clear_at) begin
            clear = 1'b0;
            #1;
            check_val("clr_busy", {31'd0, busy}, 32'd0);
            check_val("clr_done", {31'd0, done}, 32'd0);
            check_val("clr_quot", quotient, 32'd0);
            check_val("clr_rem", remainder, 32'd0);
            check_val("clr_dbz", {31'd0, div_by_zero}, 32'd0);
            void'(sb.pop_front());
            for (int i = 0; i < 3; i++) begin
               @(posedge clock);
               #1;
               check_val("clr_nodone", {31'd0, done}, 32'd0);
            end
            clear = 1'b1;
            return;
         end
         if (done) begin
            got = 1'b1;
         end else if (busy) begin
            busy_cnt++;
         end
      end
      if (!got) begin
         check_val("done_seen", {31'd0, done}, 32'd1);
         if (sb.size() > 0) void'(sb.pop_front());
         return;
      end
      check_val("latency", 32'(cyc), 32'd33);
      check_val("busy_cycles", 32'(busy_cnt), 32'd33);
      check_val("busy_at_done", {31'd0, busy}, 32'd0);
      e = sb.pop_front();
      check_val("quotient", quotient, e.q);
      check_val("remainder", remainder, e.r);
      check_val("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.z});
      @(posedge clock);
      #1;
      check_val("done_pulse", {31'd0, done}, 32'd0);
      check_val("quot_held", quotient, e.q);
      check_val("rem_held", remainder, e.r);
   endtask

   initial begin
      #12;
      check_val("rst_busy", {31'd0, busy}, 32'd0);
      check_val("rst_done", {31'd0, done}, 32'd0);
      check_val("rst_quot", quotient, 32'd0);
      check_val("rst_rem", remainder, 32'd0);
      check_val("rst_dbz", {31'd0, div_by_zero}, 32'd0);
      @(negedge clock);
      clear = 1'b1;

      run_op(32'hFFFF_F818, 32'h0000_000C, -1, -1);
      check_val("neg_pos_q_lit", quotient, 32'hFFFF_FF58);
      check_val("neg_pos_r_lit", remainder, 32'hFFFF_FFF8);
      run_op(32'h0000_07E8, 32'hFFFF_FFF4, -1, -1);
      check_val("pos_neg_r_lit", remainder, 32'h0000_0008);
      run_op(32'h0000_07E8, 32'h0000_000C, -1, -1);
      check_val("pos_pos_q_lit", quotient, 32'h0000_00A8);
      run_op(32'hFFFF_9BDC, 32'h0000_0141, -1, -1);
      check_val("m25636_q_lit", quotient, 32'hFFFF_FFB1);
      check_val("m25636_r_lit", remainder, 32'hFFFF_FEEB);
      run_op(32'd7, 32'd0, -1, -1);
      check_val("dz_q_lit", quotient, 32'hFFFF_FFFF);
      run_op(32'd7, 32'd7, -1, -1);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
      check_val("ovf_q_lit", quotient, 32'h8000_0000);
      run_op(32'h8000_0000, 32'h0000_0001, -1, -1);
      run_op(32'h8000_0000, 32'h0000_0000, -1, -1);
      run_op(32'd100, 32'd7, 5, -1);
      check_val("stall_q_lit", quotient, 32'd14);
      check_val("stall_r_lit", remainder, 32'd2);
      run_op(32'hFFFF_FF9C, 32'd7, -1, 10);
      run_op(32'd100, 32'd7, -1, -1);
      for (int i = 0; i < 6; i++) begin
         run_op($urandom, (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)), -1, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule : tb_seq_divider
